// File: rtl/rgb2raw.sv
// RGB to Bayer RAW re-mosaic, fixed 2-cycle latency, Bayer order latched during vsync.
// Optional per-frame line/pixel statistics when RGB2RAW_STAT_EN is defined.
module rgb2raw #(
  parameter int unsigned DATA_W  = 8,
  parameter logic [1:0]  PATTERN = 2'd0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hdmi_hs,
  input  logic              hdmi_vs,
  input  logic              hdmi_de,
  input  logic [DATA_W-1:0] hdmi_r,
  input  logic [DATA_W-1:0] hdmi_g,
  input  logic [DATA_W-1:0] hdmi_b,
  input  logic [1:0]        bayer_pat,
  output logic              raw_hs_o,
  output logic              raw_vs_o,
  output logic              raw_de_o,
  output logic [DATA_W-1:0] raw_data_o
`ifdef RGB2RAW_STAT_EN
  ,
  output logic [15:0]       frame_lines_o,
  output logic [23:0]       frame_pix_o,
  output logic              frame_done_o
`endif
);

  typedef enum logic [1:0] {
    PH_R  = 2'b00,
    PH_G0 = 2'b01,
    PH_G1 = 2'b10,
    PH_B  = 2'b11
  } phase_e;

  logic              hs1_q, vs1_q, de1_q;
  logic [DATA_W-1:0] r1_q, g1_q, b1_q;
  phase_e            ph1_q, ph1_d;

  logic [15:0]       row_q, row_d;
  logic              col_q, col_d;
  logic [1:0]        pat_q, pat_d;

  logic              hs2_q, vs2_q, de2_q;
  logic [DATA_W-1:0] data2_q, data2_d;

  always_comb begin
    row_d = row_q;
    if (hdmi_vs) begin
      row_d = '0;
    end else if (de1_q && !hdmi_de) begin
      row_d = row_q + 16'd1;
    end

    col_d = hdmi_de ? ~col_q : 1'b0;
    pat_d = hdmi_vs ? bayer_pat : pat_q;

    // Phase is resolved against the pixel now on the inputs and carried alongside it.
    ph1_d = phase_e'(pat_q ^ {row_q[0], col_q});

    data2_d = '0;
    if (de1_q) begin
      case (ph1_q)
        PH_R:    data2_d = r1_q;
        PH_B:    data2_d = b1_q;
        default: data2_d = g1_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      ph1_q   <= PH_R;
      row_q   <= '0;
      col_q   <= 1'b0;
      pat_q   <= PATTERN;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      de2_q   <= 1'b0;
      data2_q <= '0;
    end else begin
      hs1_q   <= hdmi_hs;
      vs1_q   <= hdmi_vs;
      de1_q   <= hdmi_de;
      r1_q    <= hdmi_r;
      g1_q    <= hdmi_g;
      b1_q    <= hdmi_b;
      ph1_q   <= ph1_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pat_q   <= pat_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      de2_q   <= de1_q;
      data2_q <= data2_d;
    end
  end

  assign raw_hs_o   = hs2_q;
  assign raw_vs_o   = vs2_q;
  assign raw_de_o   = de2_q;
  assign raw_data_o = data2_q;

`ifdef RGB2RAW_STAT_EN
  logic [23:0] pix_q, pix_d;
  logic [15:0] lines_q, lines_d;
  logic [23:0] fpix_q, fpix_d;
  logic        done_q, done_d;
  logic        vs_rise;

  always_comb begin
    vs_rise = hdmi_vs & ~vs1_q;

    pix_d = pix_q;
    if (hdmi_vs) begin
      pix_d = '0;
    end else if (hdmi_de && (pix_q != '1)) begin
      pix_d = pix_q + 24'd1;
    end

    lines_d = vs_rise ? row_q : lines_q;
    fpix_d  = vs_rise ? pix_q : fpix_q;
    done_d  = vs_rise;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_q   <= '0;
      lines_q <= '0;
      fpix_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      lines_q <= lines_d;
      fpix_q  <= fpix_d;
      done_q  <= done_d;
    end
  end

  assign frame_lines_o = lines_q;
  assign frame_pix_o   = fpix_q;
  assign frame_done_o  = done_q;
`endif

endmodule

// File: tb/tb_rgb2raw.sv
// Directed, table-driven bench for rgb2raw; each record's expected output is checked 2 cycles after it is driven.
module tb_rgb2raw;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       hdmi_hs = 1'b0, hdmi_vs = 1'b0, hdmi_de = 1'b0;
  logic [7:0] hdmi_r = '0, hdmi_g = '0, hdmi_b = '0;
  logic [1:0] bayer_pat = '0;
  logic       raw_hs_o, raw_vs_o, raw_de_o;
  logic [7:0] raw_data_o;
`ifdef RGB2RAW_STAT_EN
  logic [15:0] frame_lines_o;
  logic [23:0] frame_pix_o;
  logic        frame_done_o;
`endif

  rgb2raw #(.DATA_W(8), .PATTERN(2'd0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .hdmi_hs    (hdmi_hs),
    .hdmi_vs    (hdmi_vs),
    .hdmi_de    (hdmi_de),
    .hdmi_r     (hdmi_r),
    .hdmi_g     (hdmi_g),
    .hdmi_b     (hdmi_b),
    .bayer_pat  (bayer_pat),
    .raw_hs_o   (raw_hs_o),
    .raw_vs_o   (raw_vs_o),
    .raw_de_o   (raw_de_o),
    .raw_data_o (raw_data_o)
`ifdef RGB2RAW_STAT_EN
    ,
    .frame_lines_o (frame_lines_o),
    .frame_pix_o   (frame_pix_o),
    .frame_done_o  (frame_done_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hs, vs, de;
    logic [7:0] r, g, b;
    logic [1:0] pat;
    logic [7:0] exp;
    string      tag;
  } vec_t;

  vec_t        tbl[$];
  logic [1:0]  cur_pat;
  string       cur_tag;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic hs, input logic vs, input logic de,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [7:0] exp);
    vec_t v;
    v.hs = hs; v.vs = vs; v.de = de;
    v.r = r; v.g = g; v.b = b;
    v.pat = cur_pat; v.exp = exp; v.tag = cur_tag;
    tbl.push_back(v);
  endtask

  // Blanking carries all-ones colour so any leak into raw_data_o is visible.
  task automatic add_vs(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) add(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00);
  endtask

  task automatic add_blank(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) add(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00);
  endtask

  task automatic add_pix(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    add(1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, e0);
    add(1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, e1);
    add(1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, e2);
    add(1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, e3);
  endtask

  task automatic add_line(input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    add_pix(e0, e1, e2, e3);
    add_blank(2);
  endtask

  task automatic drive_idle();
    hdmi_hs = 1'b0; hdmi_vs = 1'b0; hdmi_de = 1'b0;
    hdmi_r = '0; hdmi_g = '0; hdmi_b = '0;
  endtask

  task automatic run_table();
    int unsigned n;
    n = tbl.size();
    for (int unsigned i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("%s[%0d]", tbl[i-2].tag, i - 2),
            {21'd0, raw_hs_o, raw_vs_o, raw_de_o, raw_data_o},
            {21'd0, tbl[i-2].hs, tbl[i-2].vs, tbl[i-2].de, tbl[i-2].exp});
      end
      if (i < n) begin
        hdmi_hs = tbl[i].hs; hdmi_vs = tbl[i].vs; hdmi_de = tbl[i].de;
        hdmi_r = tbl[i].r; hdmi_g = tbl[i].g; hdmi_b = tbl[i].b;
        bayer_pat = tbl[i].pat;
      end else begin
        drive_idle();
      end
    end
    tbl.delete();
  endtask

  initial begin
    bayer_pat = 2'd3;
    repeat (3) @(negedge clk);
    chk("reset_outs", {28'd0, raw_hs_o, raw_vs_o, raw_de_o, |raw_data_o}, 32'd0);
`ifdef RGB2RAW_STAT_EN
    chk("reset_stats", {7'd0, frame_done_o, frame_lines_o | frame_pix_o[15:0], frame_pix_o[23:16]}, 32'd0);
`endif
    resetn = 1'b1;

    // Reset-time pattern (RGGB) holds even though bayer_pat=3 outside vsync.
    cur_pat = 2'd3; cur_tag = "rst_rggb";
    add_blank(2);
    add_line(8'h11, 8'h22, 8'h11, 8'h22);
    add_line(8'h22, 8'h33, 8'h22, 8'h33);
    add_line(8'h11, 8'h22, 8'h11, 8'h22);
    add_line(8'h22, 8'h33, 8'h22, 8'h33);

    cur_tag = "bggr";
    add_vs(3); add_blank(2);
    add_line(8'h33, 8'h22, 8'h33, 8'h22);
    add_line(8'h22, 8'h11, 8'h22, 8'h11);
    add_line(8'h33, 8'h22, 8'h33, 8'h22);
    add_line(8'h22, 8'h11, 8'h22, 8'h11);

    cur_pat = 2'd0; cur_tag = "midchg";
    add_vs(2); add_blank(2);
    add_line(8'h11, 8'h22, 8'h11, 8'h22);
    add_line(8'h22, 8'h33, 8'h22, 8'h33);
    cur_pat = 2'd2;
    add_line(8'h11, 8'h22, 8'h11, 8'h22);
    add_line(8'h22, 8'h33, 8'h22, 8'h33);

    cur_tag = "gbrg";
    add_vs(2); add_blank(2);
    add_line(8'h22, 8'h33, 8'h22, 8'h33);
    add_line(8'h11, 8'h22, 8'h11, 8'h22);

    // vs mid-line: row parity clears at once, column parity keeps running.
    cur_pat = 2'd0; cur_tag = "vs_midline";
    add_vs(2); add_blank(2);
    add_line(8'h11, 8'h22, 8'h11, 8'h22);
    add(1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 8'h22);
    add(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h33);
    add(1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 8'h11);
    add(1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 8'h22);
    add_blank(2);
    add_line(8'h22, 8'h33, 8'h22, 8'h33);

    // vs on the de-falling cycle of row 0: next line must still be row 0.
    cur_tag = "vs_defall";
    add_vs(2); add_blank(2);
    add_pix(8'h11, 8'h22, 8'h11, 8'h22);
    add(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    add_blank(2);
    add_line(8'h11, 8'h22, 8'h11, 8'h22);
    run_table();

    // Reset mid-line.
    @(negedge clk); hdmi_vs = 1'b1; bayer_pat = 2'd3;
    @(negedge clk); hdmi_vs = 1'b0;
    hdmi_r = 8'h11; hdmi_g = 8'h22; hdmi_b = 8'h33;
    @(negedge clk); hdmi_de = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_pix", {23'd0, raw_de_o, raw_data_o}, {23'd0, 1'b1, 8'h33});
    #2 resetn = 1'b0;
    drive_idle();
    #1 chk("async_reset", {21'd0, raw_hs_o, raw_vs_o, raw_de_o, raw_data_o}, 32'd0);
    @(negedge clk);
    chk("held_reset", {21'd0, raw_hs_o, raw_vs_o, raw_de_o, raw_data_o}, 32'd0);
`ifdef RGB2RAW_STAT_EN
    chk("held_reset_stats", {7'd0, frame_done_o, frame_lines_o | frame_pix_o[15:0], frame_pix_o[23:16]}, 32'd0);
`endif
    resetn = 1'b1;

    cur_pat = 2'd3; cur_tag = "post_rst";
    add_blank(2);
    add_line(8'h11, 8'h22, 8'h11, 8'h22);
    add_line(8'h22, 8'h33, 8'h22, 8'h33);
    cur_tag = "realign";
    add_vs(2); add_blank(2);
    add_line(8'h33, 8'h22, 8'h33, 8'h22);
    add_line(8'h22, 8'h11, 8'h22, 8'h11);
    run_table();

`ifdef RGB2RAW_STAT_EN
    // 16x6 frame between two vsyncs.
    @(negedge clk); hdmi_vs = 1'b1;
    @(negedge clk); hdmi_vs = 1'b0;
    for (int l = 0; l < 6; l++) begin
      for (int p = 0; p < 16; p++) begin
        @(negedge clk); hdmi_de = 1'b1;
      end
      repeat (3) begin
        @(negedge clk); hdmi_de = 1'b0;
      end
    end
    @(negedge clk); hdmi_vs = 1'b1;
    @(negedge clk);
    chk("stat_done_pulse", {31'd0, frame_done_o}, 32'd1);
    chk("stat_lines", {16'd0, frame_lines_o}, 32'd6);
    chk("stat_pix", {8'd0, frame_pix_o}, 32'd96);
    @(negedge clk); hdmi_vs = 1'b0;
    chk("stat_done_1cyc", {31'd0, frame_done_o}, 32'd0);
    chk("stat_hold", {frame_pix_o[15:0], frame_lines_o}, {16'd96, 16'd6});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb2raw.md
Name: rgb2raw

Overview:
- Re-mosaics a parallel RGB video stream (HDMI-style timing: hs/vs/de plus R/G/B) into a single-channel Bayer RAW stream with the same timing.
- This is the transmit-side counterpart of the RAW-to-RGB demosaic stage. It feeds synthetic or processed RGB frames back into the RAW/MIPI path for loopback and test.
- Bayer phase is selectable per frame. The selection is latched during vertical sync.

Parameters:
- DATA_W, 8, bits per colour component and per RAW sample.
- PATTERN, 0, reset-time Bayer order: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- hdmi_hs  in  1  horizontal sync, passed through.
- hdmi_vs  in  1  vertical sync, active high; frame boundary.
- hdmi_de  in  1  data enable; high on active pixels.
- hdmi_r  in  DATA_W  red component.
- hdmi_g  in  DATA_W  green component.
- hdmi_b  in  DATA_W  blue component.
- bayer_pat  in  2  requested Bayer order, same encoding as PATTERN.
- raw_hs_o  out  1  hs delayed by 2 cycles.
- raw_vs_o  out  1  vs delayed by 2 cycles.
- raw_de_o  out  1  de delayed by 2 cycles.
- raw_data_o  out  DATA_W  Bayer sample.

Behaviour:
- Reset values:
  - all outputs 0.
  - row counter 0, column parity 0.
  - pattern register = PATTERN.
  - internal pipeline registers 0.
- Latency:
  - fixed 2 cycles from inputs to outputs for all four output signals.
  - syncs, de and data stay exactly aligned.
- Stage 1 registers hs/vs/de and R/G/B. Stage 2 selects and registers the output sample.
- Row counter (16 bit):
  - cleared every cycle hdmi_vs=1.
  - otherwise increments on the de falling edge (de registered=1, hdmi_de=0).
  - wraps at 2^16 without error.
  - only bit 0 (row parity) affects colour selection.
- Column parity:
  - cleared whenever hdmi_de=0.
  - toggles every cycle hdmi_de=1; the first active pixel of a line has parity 0.
- Pattern register:
  - loads bayer_pat on every cycle hdmi_vs=1; holds otherwise.
  - a change of bayer_pat mid-frame has no effect until the next vs.
- Selection:
  - phase = pattern_reg XOR {row_parity, col_parity}.
  - phase 00 -> R; 01 -> G; 10 -> G; 11 -> B.
  - this yields RGGB/GRBG/GBRG/BGGR for pattern 0/1/2/3.
- raw_data_o = selected component when delayed de=1, else 0. No blanking-interval data leaks.
- Simultaneous vs=1 and de falling edge: vs wins; the row counter clears.
- vs asserted mid-line (de=1): row parity clears immediately; column parity continues until de falls.
- Reset mid-frame:
  - outputs go to 0 asynchronously.
  - after release, the first line seen is treated as row 0 until the next vs re-aligns.
- No backpressure; the block accepts one pixel per cycle unconditionally.

Optional Feature:
- Macro RGB2RAW_STAT_EN.
- When defined, three extra output ports are added:
  - frame_lines_o (16 bit)
  - frame_pix_o (24 bit)
  - frame_done_o (1 bit)
- A 24-bit pixel counter counts de=1 cycles, saturating at 2^24-1, and clears on vs.
- On the vs rising edge (vs=1, registered vs=0):
  - frame_lines_o <= row counter.
  - frame_pix_o <= pixel counter.
  - frame_done_o pulses high for exactly 1 cycle.
- Both values hold until the next vs rising edge. All three ports reset to 0.
- When the macro is not defined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset default, PATTERN=0, 4x4 frame with R=8'h11, G=8'h22, B=8'h33 -> line 0 raw_data_o = 11,22,11,22; line 1 = 22,33,22,33; each output exactly 2 cycles after the matching input.
- bayer_pat=3 during vs, same frame -> line 0 = 33,22,33,22; line 1 = 22,11,22,11.
- bayer_pat changed 0->2 mid-frame -> current frame keeps RGGB; next frame line 0 = 22,33,22,33.
- Blanking check: de=0 with R/G/B=8'hFF -> raw_data_o=0 and raw_de_o=0; hs/vs appear delayed by exactly 2 cycles.
- resetn pulsed low mid-line -> all outputs 0 the same cycle; next vs realigns the pattern, verified on the following frame.
- With RGB2RAW_STAT_EN, 640x480 frame -> at the next vs rising edge, frame_lines_o=480, frame_pix_o=307200, frame_done_o high for 1 cycle.
